// File: rtl/alien_bullet.sv
// Enemy shot controller: cooldown, pseudo-random column pick, bottom-most live alien launch,
// per-frame descent and retirement on player hit, shield hit or screen bottom.
module alien_bullet #(
  parameter int          N_COLS       = 11,
  parameter int          N_ROWS       = 5,
  parameter int          COL_PITCH    = 16,
  parameter int          ROW_PITCH    = 16,
  parameter int          BULLET_STEP  = 2,
  parameter int          BULLET_Y_MAX = 479,
  parameter int          COOLDOWN     = 60,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic                     frame_clk,
  input  logic                     Reset,
  input  logic                     enable,
  input  logic [N_COLS*N_ROWS-1:0] alien_alive,
  input  logic [9:0]               formation_X,
  input  logic [9:0]               formation_Y,
  input  logic                     hit_player,
  input  logic                     hit_shield,
  output logic [9:0]               bullet_X,
  output logic [9:0]               bullet_Y,
  output logic                     bullet_on_screen,
  output logic                     player_hit
);

  localparam int CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COOL   = 2'd1;
  localparam logic [1:0] S_SELECT = 2'd2;
  localparam logic [1:0] S_TRAVEL = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [CD_W-1:0]  cd_q, cd_d;
  logic [COL_W-1:0] scol_q, scol_d;
  logic [COL_W-1:0] scnt_q, scnt_d;
  logic [9:0]       bx_q, bx_d;
  logic [9:0]       by_q, by_d;
  logic             on_q, on_d;
  logic             ph_q, ph_d;

  logic             found;
  logic [ROW_W-1:0] hit_row;
  logic [3:0]       nib;
  logic [COL_W-1:0] start_col;
  logic [10:0]      x_sum, y_sum, y_step;
  logic             past_bottom;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign nib    = lfsr_q[3:0];
  assign start_col = COL_W'((nib >= 4'(N_COLS)) ? nib - 4'(N_COLS) : nib);

  // Later rows overwrite earlier ones, so hit_row ends up as the bottom-most live alien.
  always_comb begin
    found   = 1'b0;
    hit_row = '0;
    for (int unsigned r = 0; r < N_ROWS; r++) begin
      for (int unsigned c = 0; c < N_COLS; c++) begin
        if (scol_q == COL_W'(c) && alien_alive[r*N_COLS+c]) begin
          found   = 1'b1;
          hit_row = ROW_W'(r);
        end
      end
    end
  end

  assign x_sum  = {1'b0, formation_X} + 11'(scol_q) * 11'(COL_PITCH) + 11'(COL_PITCH / 2);
  assign y_sum  = {1'b0, formation_Y} + (11'(hit_row) + 11'd1) * 11'(ROW_PITCH);
  assign y_step = {1'b0, by_q} + 11'(BULLET_STEP);
  assign past_bottom = y_step > 11'(BULLET_Y_MAX);

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    scol_d  = scol_q;
    scnt_d  = scnt_q;
    bx_d    = bx_q;
    by_d    = by_q;
    on_d    = on_q;
    ph_d    = 1'b0;
    if (state_q != S_IDLE && !enable) begin
      state_d = S_IDLE;
      on_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_d = S_COOL;
            cd_d    = CD_W'(COOLDOWN - 1);
          end
        end
        S_COOL: begin
          if (cd_q == '0) begin
            state_d = S_SELECT;
            scol_d  = start_col;
            scnt_d  = '0;
          end else begin
            cd_d = cd_q - 1'b1;
          end
        end
        S_SELECT: begin
          if (found) begin
            bx_d    = 10'(x_sum);
            by_d    = 10'(y_sum);
            on_d    = 1'b1;
            state_d = S_TRAVEL;
          end else if (scnt_q == COL_W'(N_COLS - 1)) begin
            state_d = S_IDLE;
          end else begin
            scol_d = (scol_q == COL_W'(N_COLS - 1)) ? '0 : scol_q + 1'b1;
            scnt_d = scnt_q + 1'b1;
          end
        end
        S_TRAVEL: begin
          if (hit_player || hit_shield || past_bottom) begin
            ph_d    = hit_player;
            on_d    = 1'b0;
            state_d = S_COOL;
            cd_d    = CD_W'(COOLDOWN - 1);
          end else begin
            by_d = 10'(y_step);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      cd_q    <= '0;
      scol_q  <= '0;
      scnt_q  <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      on_q    <= 1'b0;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cd_q    <= cd_d;
      scol_q  <= scol_d;
      scnt_q  <= scnt_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      on_q    <= on_d;
      ph_q    <= ph_d;
    end
  end

  assign bullet_X         = bx_q;
  assign bullet_Y         = by_q;
  assign bullet_on_screen = on_q;
  assign player_hit       = ph_q;

endmodule

// File: tb/tb_alien_bullet.sv
// Scoreboard bench for alien_bullet: stimulus pushes expected shot appear/retire events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_alien_bullet;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b1;
  logic        enable = 1'b0;
  logic [54:0] alien_alive = '1;
  logic [9:0]  formation_X = 10'd100;
  logic [9:0]  formation_Y = 10'd50;
  logic        hit_player = 1'b0;
  logic        hit_shield = 1'b0;
  logic [9:0]  bullet_X, bullet_Y;
  logic        bullet_on_screen, player_hit;

  alien_bullet #(.COOLDOWN(4)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .enable(enable), .alien_alive(alien_alive),
    .formation_X(formation_X), .formation_Y(formation_Y),
    .hit_player(hit_player), .hit_shield(hit_shield),
    .bullet_X(bullet_X), .bullet_Y(bullet_Y),
    .bullet_on_screen(bullet_on_screen), .player_hit(player_hit)
  );

  always #5 frame_clk = ~frame_clk;

  int         cyc = 0;
  logic [7:0] m_lfsr;
  always @(posedge frame_clk) cyc <= cyc + 1;
  always @(posedge frame_clk or posedge Reset)
    if (Reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

  typedef struct {
    int kind;   // 0 = shot appears, 1 = shot retires
    int x;
    int y;
    bit chk_y;
    int cyc;
    bit pulse;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int col_at(input logic [7:0] l, input int n);
    logic [7:0] v = l;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return (v[3:0] >= 4'd11) ? int'(v[3:0]) - 11 : int'(v[3:0]);
  endfunction

  function automatic int scan_cycles(input int s, input int target);
    return ((target - s + 11) % 11) + 1;
  endfunction

  task automatic push_appear(input int x, input int y, input int at);
    exp_t e;
    e.kind = 0; e.x = x; e.y = y; e.chk_y = 1'b1; e.cyc = at; e.pulse = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_retire(input int y, input bit chk_y, input int at, input bit pulse);
    exp_t e;
    e.kind = 1; e.x = 0; e.y = y; e.chk_y = chk_y; e.cyc = at; e.pulse = pulse;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge frame_clk);
  endtask

  logic prev_on = 1'b0;
  logic prev_ph = 1'b0;
  always @(negedge frame_clk) begin
    if (Reset) begin
      prev_on <= 1'b0;
      prev_ph <= 1'b0;
    end else begin
      if (player_hit) chk("pulse_width", int'(prev_ph), 0);
      if ((bullet_on_screen != prev_on) || player_hit) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("event_kind", (bullet_on_screen && !prev_on) ? 0 : 1, e.kind);
          chk("event_cycle", cyc, e.cyc);
          if (e.kind == 0) begin
            chk("shot_x", int'(bullet_X), e.x);
            chk("shot_y", int'(bullet_Y), e.y);
          end else begin
            if (e.chk_y) chk("retire_y", int'(bullet_Y), e.y);
            chk("player_hit", int'(player_hit), int'(e.pulse));
          end
        end
      end
      prev_on <= bullet_on_screen;
      prev_ph <= player_hit;
    end
  end

  initial begin
    int c, a, r, a2, s, s2;
    logic [7:0] l;

    repeat (3) @(negedge frame_clk);
    chk("reset_x", int'(bullet_X), 0);
    chk("reset_y", int'(bullet_Y), 0);
    chk("reset_on", int'(bullet_on_screen), 0);
    chk("reset_hit", int'(player_hit), 0);

    // Straight out of reset: seed A5 advanced 4 times is 8'h54, start column 4.
    #1 Reset = 1'b0;
    enable = 1'b1;
    c = cyc; a = c + 6;
    push_appear(172, 130, a);
    push_retire(136, 1'b1, a + 4, 1'b0);
    wait_cyc(a + 3); enable = 1'b0;
    wait_cyc(a + 6);

    // Single live alien at row 1, col 3.
    alien_alive = '0; alien_alive[14] = 1'b1; formation_X = 10'd108;
    c = cyc; l = m_lfsr; enable = 1'b1;
    s = col_at(l, 4); a = c + 5 + scan_cycles(s, 3);
    push_appear(164, 82, a);
    push_retire(84, 1'b1, a + 2, 1'b0);
    wait_cyc(a + 1); hit_shield = 1'b1;
    wait_cyc(a + 2); hit_shield = 1'b0; enable = 1'b0;
    wait_cyc(a + 4);

    // Bottom-of-screen retirement and cooldown reload.
    alien_alive = '1; formation_X = 10'd100; formation_Y = 10'd390;
    c = cyc; l = m_lfsr; enable = 1'b1;
    s = col_at(l, 4); a = c + 6; r = a + 5;
    push_appear(108 + 16 * s, 470, a);
    push_retire(478, 1'b1, r, 1'b0);
    s2 = col_at(l, r + 3 - c); a2 = r + 5;
    push_appear(108 + 16 * s2, 470, a2);
    push_retire(470, 1'b1, a2 + 1, 1'b0);
    wait_cyc(a2); enable = 1'b0;
    wait_cyc(a2 + 3);

    // Hits ignored while cooling down; both hits at once in flight give one pulse.
    formation_Y = 10'd50;
    c = cyc; l = m_lfsr; hit_player = 1'b1; hit_shield = 1'b1; enable = 1'b1;
    s = col_at(l, 4); a = c + 6;
    push_appear(108 + 16 * s, 130, a);
    push_retire(134, 1'b1, a + 3, 1'b1);
    wait_cyc(c + 3); hit_player = 1'b0; hit_shield = 1'b0;
    wait_cyc(a + 2); hit_player = 1'b1; hit_shield = 1'b1;
    wait_cyc(a + 3); hit_player = 1'b0; hit_shield = 1'b0; enable = 1'b0;
    wait_cyc(a + 6);

    // Empty formation: 11 select cycles, back to idle, then a fresh cooldown round.
    alien_alive = '0;
    c = cyc; l = m_lfsr; enable = 1'b1;
    wait_cyc(c + 18);
    chk("no_shot_empty", int'(bullet_on_screen), 0);
    alien_alive = '1;
    s = col_at(l, 20); a = c + 22;
    push_appear(108 + 16 * s, 130, a);
    push_retire(130, 1'b1, a + 1, 1'b0);
    wait_cyc(a); enable = 1'b0;
    wait_cyc(a + 3);

    // Async reset while a shot is in flight, then relaunch from the seed.
    c = cyc; l = m_lfsr; enable = 1'b1;
    s = col_at(l, 4); a = c + 6;
    push_appear(108 + 16 * s, 130, a);
    wait_cyc(a + 2);
    #2 Reset = 1'b1;
    #1;
    chk("async_reset_x", int'(bullet_X), 0);
    chk("async_reset_y", int'(bullet_Y), 0);
    chk("async_reset_on", int'(bullet_on_screen), 0);
    chk("async_reset_hit", int'(player_hit), 0);
    @(negedge frame_clk);
    #1 Reset = 1'b0;
    c = cyc; a = c + 6;
    push_appear(172, 130, a);
    push_retire(130, 1'b1, a + 1, 1'b0);
    wait_cyc(a); enable = 1'b0;
    wait_cyc(a + 3);

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge frame_clk);
    chk("missing_event", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
